// File: rtl/iaddr_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// The memory instantiation reuses DEF_DP/DEF_AW so both ends agree on geometry.
package iaddr_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DEF_DP = 1024;
    localparam int unsigned DEF_AW = 16;
    localparam int unsigned DEF_DW = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StDatLo,
        StDatHi,
        StWrite,
        StCksum,
        StFin
    } state_e;

    // States in which the loader is willing to take a stream byte.
    function automatic logic state_accepts(state_e st);
        return (st == StLenLo) || (st == StLenHi) || (st == StDatLo) ||
               (st == StDatHi) || (st == StCksum);
    endfunction

endpackage

// File: rtl/iaddr_loader.sv
// Program loader: turns a byte stream (16-bit little-endian length header followed by
// little-endian 16-bit words) into single-cycle writes at consecutive addresses from 0.
// Words at addresses >= DP are consumed but not written, and flag err.
// Optional: define IADDR_LOADER_CKSUM_EN to expect a trailing XOR checksum byte.
module iaddr_loader
    import iaddr_loader_pkg::*;
#(
    parameter int unsigned DP = DEF_DP,
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned AW = DEF_AW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [BYTE_W-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic              mem_we_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_din_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    // One extra counter bit so len = 2**AW - 1 terminates without wrapping.
    localparam logic [AW:0] DpLim = DP[AW:0];

`ifdef IADDR_LOADER_CKSUM_EN
    localparam state_e StEnd = StCksum;
`else
    localparam state_e StEnd = StFin;
`endif

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   len_lo_q;
    logic [AW-1:0]       len_q;
    logic [BYTE_W-1:0]   dat_lo_q;
    logic [AW:0]         cnt_q;
    logic [AW:0]         cnt_inc;
    logic [AW-1:0]       hdr;
    logic                xfer;
    logic                s_ready_q, mem_we_q, busy_q, done_q, err_q;
    logic [AW-1:0]       mem_addr_q;
    logic [DW-1:0]       mem_din_q;
`ifdef IADDR_LOADER_CKSUM_EN
    logic [BYTE_W-1:0]   xor_q;
`endif

    // Next-state decode; byte transfers only when the registered ready is high.
    always_comb begin
        state_d = state_q;
        xfer    = s_valid_i & s_ready_q;
        hdr     = AW'({s_data_i, len_lo_q});
        cnt_inc = cnt_q + 1'b1;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StLenLo;
            StLenLo: if (xfer) state_d = StLenHi;
            StLenHi: if (xfer) state_d = (hdr == '0) ? StEnd : StDatLo;
            StDatLo: if (xfer) state_d = StDatHi;
            StDatHi: if (xfer) state_d = StWrite;
            StWrite: state_d = (cnt_inc == {1'b0, len_q}) ? StEnd : StDatLo;
`ifdef IADDR_LOADER_CKSUM_EN
            StCksum: if (xfer) state_d = StFin;
`endif
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, datapath and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            len_lo_q   <= '0;
            len_q      <= '0;
            dat_lo_q   <= '0;
            cnt_q      <= '0;
            s_ready_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IADDR_LOADER_CKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            s_ready_q <= state_accepts(state_d);
            busy_q    <= (state_d != StIdle);
            done_q    <= (state_d == StFin);
            mem_we_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        err_q <= 1'b0;
                        cnt_q <= '0;
`ifdef IADDR_LOADER_CKSUM_EN
                        xor_q <= '0;
`endif
                    end
                end
                StLenLo: if (xfer) len_lo_q <= s_data_i;
                StLenHi: begin
                    if (xfer) begin
                        len_q <= hdr;
                        if ({1'b0, hdr} > DpLim) err_q <= 1'b1;
                    end
                end
                StDatLo: if (xfer) dat_lo_q <= s_data_i;
                StDatHi: begin
                    if (xfer) begin
                        // Write strobe lands in the WRITE cycle; out-of-range words are dropped.
                        mem_we_q   <= (cnt_q < DpLim);
                        mem_addr_q <= cnt_q[AW-1:0];
                        mem_din_q  <= DW'({s_data_i, dat_lo_q});
                    end
                end
                StWrite: cnt_q <= cnt_inc;
`ifdef IADDR_LOADER_CKSUM_EN
                StCksum: if (xfer && (s_data_i != xor_q)) err_q <= 1'b1;
`endif
                default: ;
            endcase
`ifdef IADDR_LOADER_CKSUM_EN
            if (xfer && (state_q != StCksum)) xor_q <= xor_q ^ s_data_i;
`endif
        end
    end

    assign s_ready_o  = s_ready_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_din_o  = mem_din_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_iaddr_loader.sv
// Self-checking bench for iaddr_loader, run with a small memory depth so the
// drop-past-end behaviour is reachable. Expected writes come from the byte stream.
module tb_iaddr_loader;
    import iaddr_loader_pkg::*;

    localparam int unsigned TDP = 4;
    localparam int unsigned TAW = 16;
    localparam int unsigned TDW = 16;

    logic           clk = 1'b0;
    logic           rst_n, start, s_valid, s_ready, mem_we, busy, done, err;
    logic [7:0]     s_data;
    logic [TAW-1:0] mem_addr;
    logic [TDW-1:0] mem_din;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    iaddr_loader #(.DP(TDP), .DW(TDW), .AW(TAW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .s_data_i   (s_data),
        .s_valid_i  (s_valid),
        .s_ready_o  (s_ready),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_din_o  (mem_din),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    logic [15:0] words[$];
    logic [7:0]  stream[$];
    logic [31:0] exp_q[$];
    logic [31:0] wr_q[$];
    bit          exp_err;
    int          done_cnt, overlap_cnt, lat_cnt;
    bit          prev_xfer = 1'b0;

    // Observe between edges: outputs are stable and inputs already hold next-edge values.
    always @(negedge clk) begin
        #1;
        if (mem_we) begin
            wr_q.push_back({mem_addr, mem_din});
            if (!prev_xfer) lat_cnt++;
            if (s_ready) overlap_cnt++;
        end
        if (done) done_cnt++;
        prev_xfer = s_valid && s_ready;
    end

    // Reference: stream layout and the writes it must produce.
    function automatic void build_model(input bit bad_ck);
        logic [7:0]  x;
        logic [15:0] len;
        len = 16'(words.size());
        stream.delete();
        exp_q.delete();
        stream.push_back(len[7:0]);
        stream.push_back(len[15:8]);
        foreach (words[i]) begin
            stream.push_back(words[i][7:0]);
            stream.push_back(words[i][15:8]);
            if (i < TDP) exp_q.push_back({16'(i), words[i]});
        end
        exp_err = (int'(len) > TDP);
        x = 8'h00;
        foreach (stream[i]) x ^= stream[i];
`ifdef IADDR_LOADER_CKSUM_EN
        stream.push_back(x ^ {7'b0, bad_ck});
        exp_err |= bad_ck;
`else
        if (bad_ck) x = ~x;
`endif
    endfunction

    function automatic void rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(16'($urandom));
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        n = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            tests++;
            fails++;
            $display("FAIL s_ready_timeout: s_ready=0 required 1 within %0d cycles", n);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic kick_start();
        @(negedge clk);
        wr_q.delete();
        done_cnt    = 0;
        overlap_cnt = 0;
        lat_cnt     = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_load(input bit gaps);
        int n;
        kick_start();
        foreach (stream[i]) send_byte(stream[i], gaps);
        n = 0;
        while (done_cnt == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) @(negedge clk);
        tests++;
        if ({s_ready, mem_we, mem_addr, mem_din, busy, done, err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: rdy=%b we=%b addr=%h din=%h busy=%b done=%b err=%b required all 0",
                     s_ready, mem_we, mem_addr, mem_din, busy, done, err);
        end
        rst_n = 1'b1;
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        tests++;
        if ({busy, s_ready} !== 2'b00) begin
            fails++;
            $display("FAIL idle_no_start: busy=%b s_ready=%b required 0 0", busy, s_ready);
        end
    endtask

    task automatic test_basic();
        words = '{16'h1234, 16'h5678, 16'h9ABC};
        build_model(1'b0);
        do_load(1'b0);
        tests++;
        if (wr_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL basic_wr_count: got %0d required %0d", wr_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            tests++;
            if (wr_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL basic_wr%0d: got %h required %h", i, wr_q[i], exp_q[i]);
            end
        end
        tests++;
        if (lat_cnt != 0 || overlap_cnt != 0) begin
            fails++;
            $display("FAIL basic_timing: late=%0d overlap=%0d required 0 0", lat_cnt, overlap_cnt);
        end
        tests++;
        if (done_cnt != 1 || busy !== 1'b0 || err !== exp_err) begin
            fails++;
            $display("FAIL basic_status: done=%0d busy=%b err=%b required 1 0 %b",
                     done_cnt, busy, err, exp_err);
        end
    endtask

    task automatic test_zero_len();
        words.delete();
        build_model(1'b0);
        do_load(1'b0);
        tests++;
        if (wr_q.size() != 0 || done_cnt != 1 || err !== 1'b0) begin
            fails++;
            $display("FAIL zero_len: writes=%0d done=%0d err=%b required 0 1 0",
                     wr_q.size(), done_cnt, err);
        end
    endtask

    task automatic test_overflow();
        rand_words(6);
        build_model(1'b0);
        do_load(1'b0);
        tests++;
        if (wr_q.size() != TDP) begin
            fails++;
            $display("FAIL ovf_wr_count: got %0d required %0d", wr_q.size(), TDP);
        end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            tests++;
            if (wr_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL ovf_wr%0d: got %h required %h", i, wr_q[i], exp_q[i]);
            end
        end
        tests++;
        if (err !== 1'b1 || done_cnt != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL ovf_status: err=%b done=%0d busy=%b required 1 1 0", err, done_cnt, busy);
        end
    endtask

    task automatic test_random_gaps();
        for (int it = 0; it < 8; it++) begin
            rand_words((it == 0) ? 2 : $urandom_range(1, 6));
            build_model(1'b0);
            do_load(1'b1);
            tests++;
            if (wr_q.size() != exp_q.size()) begin
                fails++;
                $display("FAIL gaps%0d_wr_count: got %0d required %0d", it, wr_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < wr_q.size()) begin
                tests++;
                if (wr_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL gaps%0d_wr%0d: got %h required %h", it, i, wr_q[i], exp_q[i]);
                end
            end
            tests++;
            if (overlap_cnt != 0 || lat_cnt != 0 || err !== exp_err || done_cnt != 1) begin
                fails++;
                $display("FAIL gaps%0d_status: overlap=%0d late=%0d err=%b done=%0d required 0 0 %b 1",
                         it, overlap_cnt, lat_cnt, err, done_cnt, exp_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        rand_words(3);
        build_model(1'b0);
        kick_start();
        // Header, word 0, then only the low byte of word 1.
        for (int i = 0; i < 5; i++) send_byte(stream[i], 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if ({s_ready, mem_we, mem_addr, mem_din, busy, done, err} !== '0) begin
            fails++;
            $display("FAIL midrst_outputs: rdy=%b we=%b addr=%h din=%h busy=%b done=%b err=%b required all 0",
                     s_ready, mem_we, mem_addr, mem_din, busy, done, err);
        end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        tests++;
        if (wr_q.size() != 1 || done_cnt != 0) begin
            fails++;
            $display("FAIL midrst_writes: writes=%0d done=%0d required 1 0", wr_q.size(), done_cnt);
        end else begin
            tests++;
            if (wr_q[0] !== exp_q[0]) begin
                fails++;
                $display("FAIL midrst_wr0: got %h required %h", wr_q[0], exp_q[0]);
            end
        end
        rand_words(1);
        build_model(1'b0);
        do_load(1'b0);
        tests++;
        if (wr_q.size() != 1 || done_cnt != 1 || err !== 1'b0) begin
            fails++;
            $display("FAIL postrst_load: writes=%0d done=%0d err=%b required 1 1 0",
                     wr_q.size(), done_cnt, err);
        end else begin
            tests++;
            if (wr_q[0] !== exp_q[0]) begin
                fails++;
                $display("FAIL postrst_wr0: got %h required %h", wr_q[0], exp_q[0]);
            end
        end
    endtask

`ifdef IADDR_LOADER_CKSUM_EN
    task automatic test_cksum();
        words = '{16'hABCD};
        for (int bad = 0; bad < 2; bad++) begin
            build_model(bad[0]);
            do_load(1'b0);
            tests++;
            if (wr_q.size() != 1 || done_cnt != 1 || err !== exp_err) begin
                fails++;
                $display("FAIL cksum%0d: writes=%0d done=%0d err=%b required 1 1 %b",
                         bad, wr_q.size(), done_cnt, err, exp_err);
            end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        start = 1'b0; s_valid = 1'b0; s_data = 8'h00; rst_n = 1'b0;
        done_cnt = 0; overlap_cnt = 0; lat_cnt = 0;
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow();
        test_zero_len();
        test_random_gaps();
        test_reset_mid();
`ifdef IADDR_LOADER_CKSUM_EN
        test_cksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iaddr_loader.md
Name: iaddr_loader

Overview:
- Program loader: the write-side initiator for the synchronous-read instruction memory.
- Accepts a byte stream (e.g. from a UART receiver) carrying a 16-bit length header followed by 16-bit instruction words.
- Assembles each pair of bytes into a word and issues single-cycle writes at consecutive addresses from 0.
- While loading it asserts busy, which the top level uses to hold the core in reset.

Parameters:
- DP, 1024, instruction memory depth in words; addresses >= DP are never written.
- DW, 16, memory data width; fixed at 16, two bytes per word.
- AW, 16, memory address width; also the width of the length header.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  pulse; begins a load when idle.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept a byte.
- mem_we  out  1  memory write enable, high-active.
- mem_addr  out  AW  memory address.
- mem_din  out  DW  memory write data.
- busy  out  1  load in progress (IDLE excluded).
- done  out  1  one-cycle pulse on load completion.
- err  out  1  sticky error; cleared on next accepted start.

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE. All outputs are 0: s_ready, mem_we, mem_addr, mem_din, busy, done, err.
- Reset mid-load aborts the load immediately. The next cycle has mem_we=0, and no partial word is written.
- Byte transfer occurs only on a cycle with s_valid=1 and s_ready=1. s_ready is a registered function of state.
- Byte order is little-endian: low byte first.
- State machine:
  - IDLE: s_ready=0. start=1 -> LEN_LO, err<=0, word counter<=0. start while busy is ignored.
  - LEN_LO: s_ready=1. On transfer, latch len[7:0] -> LEN_HI.
  - LEN_HI: s_ready=1. On transfer, latch len[15:8]. If len==0 go to FIN, else DAT_LO. If len>DP, set err<=1.
  - DAT_LO: s_ready=1. On transfer, latch lo byte -> DAT_HI.
  - DAT_HI: s_ready=1. On transfer, latch hi byte -> WRITE.
  - WRITE: s_ready=0. For exactly one cycle: mem_we=1, mem_addr=counter, mem_din={hi,lo}. This cycle is the one after the hi byte transfer. If counter>=DP, mem_we stays 0 (word dropped, stream still consumed). Then counter+1; if counter+1==len go to FIN, else DAT_LO.
  - FIN: done=1 for one cycle -> IDLE.
- Throughput: one word per 3 cycles minimum (2 byte cycles + 1 write cycle).
- mem_we is never high outside WRITE, so the memory's read-address register is frozen only during write cycles.
- mem_addr and mem_din hold their last values after WRITE; they are valid only when mem_we=1.
- Counter width is AW+1 internally, so len=65535 terminates without wrap.
- s_valid with no transfer (s_ready=0) has no effect and the byte is not consumed.
- busy=1 in every state except IDLE. done and busy are both 1 in FIN.

Optional Feature:
- Macro: IADDR_LOADER_CKSUM_EN.
- Defined:
  - A state CKSUM is inserted between the last WRITE (or LEN_HI when len==0) and FIN.
  - CKSUM accepts one extra byte and compares it with the running XOR of all header and data bytes.
  - Mismatch sets err<=1. done still pulses.
  - The running XOR is cleared on start.
- Not defined: no CKSUM state and no XOR logic; the stream ends after the last data byte.

Decomposition:
- Shared package (iaddr_loader_pkg):
  - State encoding constants: IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, WRITE, CKSUM, FIN.
  - BYTE_W=8.
  - Default DP/AW values shared with the memory instantiation.
- No sub-module needed: byte assembly, counter and XOR accumulator stay inline. The FSM is a single registered process.

Test Plan:
- Reset then start, stream 03 00 | 34 12 | 78 56 | BC 9A -> three mem_we pulses: addr0=0x1234, addr1=0x5678, addr2=0x9ABC. Each pulse is one cycle after its hi byte. Then done one cycle, busy back to 0, err=0.
- start, stream 00 00 -> no mem_we; done pulses 2 cycles after the second byte; err=0. With CKSUM_EN, send byte 00 first, then done.
- DP=4, len=6, six words -> writes only at addr 0..3; all 12 data bytes consumed (s_ready pattern continues); err=1; done pulses.
- Random s_valid gaps, len=2 -> identical writes to the gap-free run; no byte is lost or duplicated; mem_we is never high with s_ready high.
- Assert rst_n=0 after the lo byte of word 1 -> no further mem_we; outputs all 0. A new start with len=1 writes addr 0 correctly.
- CKSUM_EN: len=1, word 0xAB CD, checksum byte 01^00^CD^AB=0x67 -> err=0. Checksum byte 0x66 -> err=1; done still pulses.
